// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_ctrl_pkg
// Description : State encoding and default timing for the multiply controller.
// Revision    : 1.0
// ============================================================================
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam int c_SETTLE_CYCLES_DEFAULT = 2;
    localparam int c_CNT_W                 = 4;

endpackage
`default_nettype wire

// File: rtl/mul_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_wb_ctrl
// Description : Latches operands for an external combinational multiplier,
//               waits for the product to settle, then writes it back.
// Revision    : 1.0
// ============================================================================
module mul_wb_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_flush,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_data2,
    input  logic [2:0] i_dest_addr,
    input  logic [7:0] i_mul_out,
    output logic [7:0] o_op1,
    output logic [7:0] o_op2,
    output logic       o_busywait,
    output logic       o_write_en,
    output logic [2:0] o_write_addr,
    output logic [7:0] o_write_data
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
        $error("mul_wb_ctrl: SETTLE_CYCLES=%0d outside legal range 1..15", SETTLE_CYCLES);
    end

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_op1;
    logic [7:0]         r_op2;
    logic [2:0]         r_write_addr;
    logic [7:0]         r_write_data;
    logic               r_write_en;
    logic               w_busywait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            if (i_flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_op1        <= i_data1;
                            r_op2        <= i_data2;
                            r_write_addr <= i_dest_addr;
                            r_cnt        <= c_CNT_LOAD;
                            r_state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // START is deliberately ignored here; the requester holds it under BUSYWAIT.
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_write_data <= i_mul_out;
                            r_write_en   <= 1'b1;
                            r_state      <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (i_start) begin
                            r_op1        <= i_data1;
                            r_op2        <= i_data2;
                            r_write_addr <= i_dest_addr;
                            r_cnt        <= c_CNT_LOAD;
                            r_state      <= SETTLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Stall is combinational on START so the PC freezes in the request cycle itself.
    always_comb begin
        w_busywait = 1'b0;
        case (r_state)
            IDLE:    w_busywait = i_start;
            SETTLE:  w_busywait = 1'b1;
            WRITE:   w_busywait = i_start;
            default: w_busywait = 1'b0;
        endcase
    end

    assign o_op1        = r_op1;
    assign o_op2        = r_op2;
    assign o_busywait   = w_busywait;
    assign o_write_en   = r_write_en;
    assign o_write_addr = r_write_addr;
    assign o_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mul_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_wb_ctrl
// Description : Directed self-checking bench for mul_wb_ctrl (SETTLE 2 and 1).
// Revision    : 1.0
// ============================================================================
module tb_mul_wb_ctrl;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start1, flush0, flush1;
    logic [7:0] data1, data2;
    logic [2:0] dest;

    logic [7:0] op1_0, op2_0, wdata0, op1_1, op2_1, wdata1;
    logic [2:0] waddr0, waddr1;
    logic       busy0, busy1, we0, we1;
    logic [7:0] mul0, mul1;
    logic signed [15:0] prod0, prod1;

    int checks   = 0;
    int failures = 0;
    wr_t sb_q[$];

    // Downstream multiplier model: low byte of the signed product.
    assign prod0 = $signed(op1_0) * $signed(op2_0);
    assign prod1 = $signed(op1_1) * $signed(op2_1);
    assign mul0  = prod0[7:0];
    assign mul1  = prod1[7:0];

    mul_wb_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start0), .i_flush(flush0),
        .i_data1(data1), .i_data2(data2), .i_dest_addr(dest), .i_mul_out(mul0),
        .o_op1(op1_0), .o_op2(op2_0), .o_busywait(busy0), .o_write_en(we0),
        .o_write_addr(waddr0), .o_write_data(wdata0)
    );

    mul_wb_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_flush(flush1),
        .i_data1(data1), .i_data2(data2), .i_dest_addr(dest), .i_mul_out(mul1),
        .o_op1(op1_1), .o_op2(op2_1), .o_busywait(busy1), .o_write_en(we1),
        .o_write_addr(waddr1), .o_write_data(wdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, check the combinational stall, push the expected write, take the sampling edge.
    task automatic launch(input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] a,
                          input logic [7:0] exp_data, input bit expect_write);
        data1  = d1;
        data2  = d2;
        dest   = a;
        start0 = 1'b1;
        #1;
        chk("busy_on_start", busy0, 1'b1);
        if (expect_write) sb_q.push_back('{addr: a, data: exp_data});
        tick();
        start0 = 1'b0;
    endtask

    // Wait (bounded) for the write strobe; stall must stay high until it arrives.
    task automatic wait_write(input string tag, input int exp_edges);
        int  n;
        wr_t e;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (we0 === 1'b1) break;
            chk({tag, "_busy_settle"}, busy0, 1'b1);
        end
        chk({tag, "_latency"}, n, exp_edges);
        chk({tag, "_busy_in_write"}, busy0, 1'b0);
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_wdata"}, wdata0, e.data);
            chk({tag, "_waddr"}, waddr0, e.addr);
        end
        tick();
        chk({tag, "_we_one_cycle"}, we0, 1'b0);
    endtask

    initial begin
        wr_t e;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        data1 = 8'h00; data2 = 8'h00; dest = 3'd0;
        #2;
        chk("rst_op1", op1_0, 8'h00);
        chk("rst_op2", op2_0, 8'h00);
        chk("rst_waddr", waddr0, 3'd0);
        chk("rst_wdata", wdata0, 8'h00);
        chk("rst_we", we0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_we_s1", we1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic: 3*5 -> 0x0F to r4; strobe after the sampling edge plus two settle edges.
        launch(8'd3, 8'd5, 3'd4, 8'h0F, 1'b1);
        chk("t1_busy_settle0", busy0, 1'b1);
        chk("t1_op1", op1_0, 8'd3);
        wait_write("t1", 2);
        chk("t1_idle_busy", busy0, 1'b0);

        launch(8'hFE, 8'h03, 3'd1, 8'hFA, 1'b1);
        wait_write("neg", 2);
        launch(8'h81, 8'h81, 3'd7, 8'h01, 1'b1);
        wait_write("minmin", 2);

        // Back-to-back with START held through SETTLE (ignored) and WRITE (accepted).
        data1 = 8'd4; data2 = 8'd4; dest = 3'd3; start0 = 1'b1;
        sb_q.push_back('{addr: 3'd3, data: 8'h10});
        tick();
        data1 = 8'd9; data2 = 8'd9; dest = 3'd6;
        tick();
        chk("b2b_ignore_op1", op1_0, 8'd4);
        chk("b2b_ignore_we", we0, 1'b0);
        data1 = 8'd7; data2 = 8'd2; dest = 3'd5;
        sb_q.push_back('{addr: 3'd5, data: 8'h0E});
        tick();
        chk("b2b_first_we", we0, 1'b1);
        chk("b2b_busy_write_start", busy0, 1'b1);
        e = sb_q.pop_front();
        chk("b2b_first_wdata", wdata0, e.data);
        chk("b2b_first_waddr", waddr0, e.addr);
        tick();
        start0 = 1'b0;
        #1;
        chk("b2b_no_bubble_busy", busy0, 1'b1);
        chk("b2b_second_op1", op1_0, 8'd7);
        chk("b2b_second_op2", op2_0, 8'd2);
        wait_write("b2b_second", 2);

        // Flush during the second settle cycle: no write, idle, data registers hold.
        launch(8'd5, 8'd5, 3'd2, 8'h00, 1'b0);
        tick();
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        #1;
        chk("flush_busy", busy0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_we", we0, 1'b0);
            tick();
        end
        chk("flush_hold_wdata", wdata0, 8'h0E);
        chk("flush_hold_op1", op1_0, 8'd5);

        // FLUSH beats START on the same edge.
        data1 = 8'h11; start0 = 1'b1; flush0 = 1'b1;
        tick();
        start0 = 1'b0; flush0 = 1'b0;
        #1;
        chk("flush_start_op1", op1_0, 8'd5);
        chk("flush_start_busy", busy0, 1'b0);
        tick();
        chk("flush_start_we", we0, 1'b0);

        // Asynchronous reset in the middle of SETTLE.
        launch(8'd6, 8'd6, 3'd1, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_op1", op1_0, 8'h00);
        chk("arst_op2", op2_0, 8'h00);
        chk("arst_waddr", waddr0, 3'd0);
        chk("arst_wdata", wdata0, 8'h00);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_we", we0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_write", we0, 1'b0);
        end
        launch(8'd2, 8'd3, 3'd6, 8'h06, 1'b1);
        wait_write("post_rst", 2);

        // SETTLE_CYCLES=1 instance: strobe one edge after the sampling edge.
        data1 = 8'hF0; data2 = 8'h03; dest = 3'd2; start1 = 1'b1;
        #1;
        chk("s1_busy_start", busy1, 1'b1);
        tick();
        start1 = 1'b0;
        #1;
        chk("s1_we_early", we1, 1'b0);
        chk("s1_busy_settle", busy1, 1'b1);
        tick();
        chk("s1_we", we1, 1'b1);
        chk("s1_wdata", wdata1, 8'hD0);
        chk("s1_waddr", waddr1, 3'd2);
        tick();
        chk("s1_we_off", we1, 1'b0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_wb_ctrl.md
MUL_WB_CTRL -- requirements
Module: mul_wb_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of clock cycles the operands are held stable before the product is sampled. Legal range is 1..15.
REQ-002 CLK  input  1  Single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  Asynchronous, active-low reset.
REQ-004 START  input  1  Multiply request from the control unit; sampled on the rising edge.
REQ-005 FLUSH  input  1  Synchronous abort of the in-flight multiply.
REQ-006 DATA1  input  8  Signed multiplicand from register file port 1.
REQ-007 DATA2  input  8  Signed multiplier from register file port 2.
REQ-008 DEST_ADDR  input  3  Destination register index.
REQ-009 MUL_OUT  input  8  Low 8 bits of the signed product from the downstream combinational multiplier.
REQ-010 OP1  output  8  Latched DATA1 driven to the multiplier.
REQ-011 OP2  output  8  Latched DATA2 driven to the multiplier.
REQ-012 BUSYWAIT  output  1  PC stall request.
REQ-013 WRITE_EN  output  1  Register-file write strobe.
REQ-014 WRITE_ADDR  output  3  Latched DEST_ADDR.
REQ-015 WRITE_DATA  output  8  Captured MUL_OUT.

Function
REQ-016 The block SHALL implement three states: IDLE, SETTLE and WRITE.
REQ-017 IDLE: on a rising edge with START=1 and FLUSH=0, the block SHALL latch DATA1->OP1, DATA2->OP2 and DEST_ADDR->WRITE_ADDR, load cnt=SETTLE_CYCLES-1, and go to SETTLE.
REQ-018 SETTLE: on each rising edge, if cnt!=0 the block SHALL decrement cnt. If cnt==0 it SHALL capture MUL_OUT->WRITE_DATA and go to WRITE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
REQ-019 WRITE: WRITE_EN SHALL be 1 for exactly this one cycle and 0 in every other state.
REQ-020 WRITE: on the next edge, the block SHALL go to IDLE, unless START=1, in which case it SHALL latch new operands and go directly to SETTLE (back-to-back multiplies, no bubble).
REQ-021 BUSYWAIT SHALL be 1 combinationally in IDLE when START=1, and 1 throughout SETTLE. It SHALL be 0 in WRITE unless START=1, and 0 in IDLE when START=0.
REQ-022 Latency: the WRITE_EN cycle SHALL begin SETTLE_CYCLES+1 edges after the edge that sampled START.
REQ-023 START asserted during SETTLE SHALL be ignored. The control unit holds it under BUSYWAIT.
REQ-024 FLUSH=1 on an edge SHALL force IDLE from any state, with WRITE_EN=0 in the following cycle. FLUSH takes priority over a simultaneous START.
REQ-025 OP1, OP2, WRITE_ADDR and WRITE_DATA SHALL hold their values in IDLE.
REQ-026 The block SHALL perform no arithmetic of its own. Product sign and truncation to 8 bits are owned by the multiplier.
REQ-027 cnt SHALL be 4 bits wide. Values of SETTLE_CYCLES outside 1..15 are a configuration error, flagged at elaboration.

Reset
REQ-028 While RESET=0, independent of CLK: state=IDLE, cnt=0, OP1=OP2=0, WRITE_ADDR=0, WRITE_DATA=0, WRITE_EN=0, BUSYWAIT=0 (given START=0).
REQ-029 Reset asserted mid-operation SHALL abandon the multiply with no write. After reset release, the first START SHALL behave as in REQ-017.

Structure
REQ-030 A shared package mul_ctrl_pkg SHALL hold the state encoding (IDLE=2'd0, SETTLE=2'd1, WRITE=2'd2) and the default SETTLE_CYCLES constant.
REQ-031 There SHALL be no sub-module. The counter and FSM are local. The multiplier is instantiated by the parent, not inside this block.

Verification
REQ-032 The bench SHALL model MUL_OUT as the low byte of signed OP1*OP2. SETTLE_CYCLES=2, DATA1=3, DATA2=5, DEST=4 -> WRITE_EN pulses one cycle, 3 edges after START; WRITE_DATA=0x0F, WRITE_ADDR=4; BUSYWAIT high for 3 cycles.
REQ-033 DATA1=0xFE (-2), DATA2=3 -> WRITE_DATA=0xFA. DATA1=0x81, DATA2=0x81 -> WRITE_DATA=0x01.
REQ-034 Back-to-back: START held through WRITE with new operands 7 and 2 -> second WRITE_EN exactly 3 edges after the first; WRITE_DATA=0x0E; no idle cycle between the two operations.
REQ-035 FLUSH=1 in the second SETTLE cycle -> no WRITE_EN; state IDLE; BUSYWAIT=0. FLUSH and START on the same edge -> stays IDLE.
REQ-036 RESET=0 asserted asynchronously mid-SETTLE -> all outputs zero immediately; no write occurs; a fresh START then completes normally.
REQ-037 SETTLE_CYCLES=1 -> WRITE_EN 2 edges after START.
